bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Sequences a single one-bit full-adder cell across WIDTH-bit operands, LSB first, one bit per clock, producing a WIDTH-bit sum and carry-out. It is the area-minimal serial counterpart to the parallel adders in the arithmetic library. It sits between a requester that presents operands with a start/ready handshake and the shared one-bit `fullAdder` datapath cell, which it owns and drives every cycle of an operation.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range is WIDTH ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- A  in  WIDTH  operand A; sampled only at acceptance.
- B  in  WIDTH  operand B; sampled only at acceptance.
- Cin  in  1  carry-in; sampled only at acceptance.
- ready  out  1  block can accept start this cycle.
- busy  out  1  serial addition in progress.
- done  out  1  one-cycle pulse; S/Cout are valid for the last accepted operation.
- S  out  WIDTH  registered sum; holds until the next done.
- Cout  out  1  registered carry-out; holds until the next done.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1, busy=0, done=0. On start=1:
  - latch A and B into shift registers opA/opB;
  - carry FF ← Cin;
  - bit counter ← 0;
  - go to RUN.
- RUN: ready=0, busy=1. Each cycle:
  - fullAdder inputs are opA[0], opB[0] and the carry FF;
  - sum bit shifts into the MSB of the accumulator shift register; opA/opB shift right;
  - carry FF ← cell Cout; counter increments.
- RUN exit: when counter = WIDTH-1, after the final shift, go to DONE. The output registers load in the same edge: S ← final accumulator, Cout ← final carry.
- DONE: done=1, busy=0, ready=1.
  - start=1: re-accept exactly as in IDLE and go to RUN (back-to-back).
  - otherwise: go to IDLE.
- start while ready=0 is ignored; no queuing.
- Operand or Cin changes after acceptance do not affect the result.
- Arithmetic is unsigned modulo 2^WIDTH. Cout is the true carry out of bit WIDTH-1: {Cout,S} = A+B+Cin.
- Reset, asserted at any time including mid-RUN, aborts immediately. The partial result is discarded and never appears on S.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, S=0, Cout=0. Internal counter, carry and shift registers are all 0.
- Acceptance edge E0 (start=1, ready=1). RUN occupies the WIDTH cycles following E0.
- done is high for exactly the cycle after edge E0+WIDTH, i.e. latency WIDTH+1 cycles from the start sample to done.
- S/Cout change only on the edge entering DONE. They are stable at all other times, including throughout the next RUN.
- Throughput: one operation per WIDTH+1 cycles with start held high.
- ready/busy/done are decoded from the state register only, never combinationally from start.
- Reset deassertion: first acceptance is possible on the first rising edge after release.

## Structure
- Package `bit_serial_adder_pkg`:
  - state enum typedef `serial_state_t` {IDLE, RUN, DONE};
  - constant DEFAULT_WIDTH = 8.
- Counter width is $clog2(WIDTH), computed locally.
- One natural sub-module: the existing `fullAdder` one-bit cell, instantiated once as the datapath.
- Control FSM, counter and shift registers live in this module (roughly 150–250 lines).

## Test plan
All scenarios use WIDTH=8.
- Zero case: A=0x00, B=0x00, Cin=0, start pulse. Required: done exactly 9 cycles after the start sample; S=0x00, Cout=0; busy high for 8 cycles.
- Full carry ripple: A=0xFF, B=0x01, Cin=0. Required: S=0x00, Cout=1. Separately, A=0xA5, B=0x5A, Cin=1: required S=0x00, Cout=1.
- MSB carry only: A=0x80, B=0x80, Cin=0. Required: S=0x00, Cout=1. Then A=0x3C, B=0x42, Cin=1: required S=0x7F, Cout=0.
- Protocol:
  - Start a first operation, then pulse start mid-RUN with different operands: required to be ignored, with the first result unchanged.
  - Change A/B during RUN: result reflects the latched operands.
  - Hold start high through DONE: next operation accepted with no IDLE cycle; done pulses every 9 cycles.
- Reset mid-operation: assert reset at cycle 4 of RUN, asynchronously between edges. Required: ready=1, busy=0, done=0, S=0, Cout=0 immediately. The next operation, 0x12+0x34, yields S=0x46, Cout=0.
- Exhaustive sweep: all A, B and Cin combinations, compared against A+B+Cin. Required: zero mismatches, and done is never asserted with busy=1.

Source files
------------

// File: rtl/bit_serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// One-bit full-adder cell: combinational, zero latency, no flow control.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Serial LSB-first adder: WIDTH+1 cycles from accepted start to done pulse.
// Accepts start only while ready (IDLE or DONE); start during RUN is dropped, never queued.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_state_t    state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             cell_sum;
  logic             cell_cout;
  logic [WIDTH-1:0] acc_next;

  fullAdder u_cell (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (cell_sum),
    .cout (cell_cout)
  );

  // acc holds only the upper WIDTH-1 result bits; the full word appears on the final shift
  assign acc_next = {cell_sum, acc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            op_a  <= A;
            op_b  <= B;
            carry <= Cin;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          acc   <= acc_next[WIDTH-1:1];
          carry <= cell_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            S     <= acc_next;
            Cout  <= cell_cout;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and swept checks of bit_serial_adder at WIDTH=8.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_s;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[9];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done && busy) overlap++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation with a single-cycle start pulse; edges counts clock edges after acceptance.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int edges, output int busy_cyc);
    @(posedge clk); #1;
    A = a; B = b; Cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    busy_cyc = 0;
    while (!done && edges < 30) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic sum_op(input int a, input int b, input int c);
    int e, bc;
    do_op(8'(a), 8'(b), 1'(c), e, bc);
    check($sformatf("sum %0h+%0h+%0d", a, b, c), 32'({Cout, S}), 32'(a + b + c));
  endtask

  initial begin
    int e, bc, n, stable_bad;

    vecs[0] = '{"zero",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{"ripple",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{"a5_5a_c1",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{"msb_only",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{"3c_42_c1",  8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0};
    vecs[5] = '{"12_34",     8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[6] = '{"max_all",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{"small",     8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[8] = '{"to_msb",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #12;
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_done",  32'(done),  32'(0));
    check("rst_S",     32'(S),     32'(0));
    check("rst_Cout",  32'(Cout),  32'(0));
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, e, bc);
      check({vecs[i].name, "_S"},    32'(S),    32'(vecs[i].exp_s));
      check({vecs[i].name, "_Cout"}, 32'(Cout), 32'(vecs[i].exp_cout));
      check({vecs[i].name, "_lat"},  32'(e),    32'(W));
      check({vecs[i].name, "_busy"}, 32'(bc),   32'(W));
      @(posedge clk); #1;
      check({vecs[i].name, "_pulse"}, 32'({done, ready, busy}), 32'(3'b010));
    end

    // start pulsed mid-RUN with new operands, and A/B/Cin left changed
    @(posedge clk); #1;
    A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrun_ready", 32'(ready), 32'(0));
    A = 8'hF0; B = 8'h0F; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin @(posedge clk); #1; n++; end
    check("midrun_lat",  32'(n),    32'(4));
    check("midrun_S",    32'(S),    32'(8'h33));
    check("midrun_Cout", 32'(Cout), 32'(0));
    @(posedge clk); #1;
    check("midrun_noqueue", 32'({ready, busy}), 32'(2'b10));

    // start held high through DONE: back-to-back acceptance
    @(posedge clk); #1;
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 30);
    check("b2b_first_lat", 32'(n), 32'(W + 1));
    check("b2b_first_S",   32'(S), 32'(8'h30));
    A = 8'h05; B = 8'h06;
    n = 0;
    stable_bad = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!done && S !== 8'h30) stable_bad++;
    end while (!done && n < 30);
    start = 1'b0;
    check("b2b_period",    32'(n),          32'(W + 1));
    check("b2b_S_stable",  32'(stable_bad), 32'(0));
    check("b2b_second_S",  32'(S),          32'(8'h0B));

    // asynchronous reset during the fourth RUN cycle
    @(posedge clk); #1;
    A = 8'h77; B = 8'h77; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'(1));
    check("abort_busy",  32'(busy),  32'(0));
    check("abort_done",  32'(done),  32'(0));
    check("abort_S",     32'(S),     32'(0));
    check("abort_Cout",  32'(Cout),  32'(0));
    @(negedge clk) reset = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, e, bc);
    check("after_abort_S",    32'(S),    32'(8'h46));
    check("after_abort_Cout", 32'(Cout), 32'(0));
    check("after_abort_lat",  32'(e),    32'(W));

    for (int a = 0; a < 256; a += 15)
      for (int b = 0; b < 256; b += 17)
        for (int c = 0; c < 2; c++)
          sum_op(a, b, c);
    for (int k = 0; k < 300; k++)
      sum_op(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));

    check("done_busy_overlap", 32'(overlap), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
